// File: rtl/mem_wb_pkg.sv
// Shared types and the load-extraction helper for the MEM->WB pipeline stage.
// Optional feature macro used by this slice: MEM_WB_PIPE_PERF_EN.
package mem_wb_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    LWU = 3'd5,
    LD  = 3'd6
  } ld_type_e;

  // Default-width view of a retiring entry for consumers outside the stage.
  localparam int WB_DATA_W = 64;
  localparam int WB_RA_W   = 5;

  typedef struct packed {
    logic                 we;
    logic [WB_RA_W-1:0]   rd;
    logic [WB_DATA_W-1:0] wdata;
  } wb_entry_t;

  // Extract a load result from a memory word (zero-extended to 64 bits).
  // Half/word lanes are aligned down to the access size. On a 32-bit
  // datapath (is64 = 0) LWU and LD collapse to LW.
  function automatic logic [63:0] load_extract(
    input logic [63:0] data,
    input logic [2:0]  off,
    input ld_type_e    ld_type,
    input logic        is64
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    logic [63:0] res;
    b = 8'(data >> {off, 3'b000});
    h = 16'(data >> {off[2:1], 4'b0000});
    w = 32'(data >> {off[2], 5'b00000});
    case (ld_type)
      LB:      res = {{56{b[7]}}, b};
      LBU:     res = {56'd0, b};
      LH:      res = {{48{h[15]}}, h};
      LHU:     res = {48'd0, h};
      LW:      res = {{32{w[31]}}, w};
      LWU:     res = is64 ? {32'd0, w} : {{32{w[31]}}, w};
      LD:      res = is64 ? data : {{32{w[31]}}, w};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_wb_load_align.sv
// Combinational load byte/half/word extraction with sign/zero extension.
module mem_wb_load_align
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [OFF_W-1:0]  off_i,
  input  ld_type_e          ld_type_i,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = DATA_W'(load_extract(64'(data_i), 3'(off_i), ld_type_i, (DATA_W == 64)));

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage: valid/ready on both sides with a head + skid
// register pair, synchronous flush, load extraction, link/r0 resolution.
// Write data is resolved at capture so every wb_* output is a register read.
// Optional feature macro: MEM_WB_PIPE_PERF_EN (perf_retired / perf_stall).
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RA_W     = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [2:0]        in_ld_type,
  input  logic              in_link,
  input  logic [DATA_W-1:0] in_pc_plus4,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [RA_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_wdata
`ifdef MEM_WB_PIPE_PERF_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_stall
`endif
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  typedef struct packed {
    logic              we;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  entry_t            head_q, head_d, skid_q, skid_d, cap_s;
  logic              head_v_q, head_v_d, skid_v_q, skid_v_d, in_ready_q;
  logic [DATA_W-1:0] load_data_s;
  logic [RA_W-1:0]   rd_final_s;
  logic              acc_s, head_free_s;

  mem_wb_load_align #(.DATA_W(DATA_W)) u_align (
    .data_i    (in_mem_data),
    .off_i     (in_alu_result[OFF_W-1:0]),
    .ld_type_i (ld_type_e'(in_ld_type)),
    .data_o    (load_data_s)
  );

  // Incoming flush kills the input; the head can be refilled when empty or leaving.
  assign acc_s       = in_valid & in_ready_q & ~flush;
  assign head_free_s = ~head_v_q | wb_ready;

  // Resolve destination, write enable and write data of the offered instruction.
  always_comb begin
    rd_final_s = in_link ? RA_W'(LINK_REG) : in_rd;
    cap_s.rd   = rd_final_s;
    cap_s.we   = (in_reg_write | in_link) & (rd_final_s != {RA_W{1'b0}});
    if (in_link) begin
      cap_s.wdata = in_pc_plus4;
    end else if (in_mem_to_reg) begin
      cap_s.wdata = load_data_s;
    end else begin
      cap_s.wdata = in_alu_result;
    end
  end

  // Head/skid next state: flush first, then skid->head before new input to keep order.
  always_comb begin
    head_d   = head_q;
    head_v_d = head_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      head_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (head_free_s) begin
      if (skid_v_q) begin
        head_d   = skid_q;
        head_v_d = 1'b1;
        skid_v_d = acc_s;
        if (acc_s) begin
          skid_d = cap_s;
        end else begin
          skid_d = skid_q;
        end
      end else begin
        head_v_d = acc_s;
        if (acc_s) begin
          head_d = cap_s;
        end else begin
          head_d = head_q;
        end
      end
    end else begin
      if (acc_s) begin
        skid_d   = cap_s;
        skid_v_d = 1'b1;
      end else begin
        skid_v_d = skid_v_q;
      end
    end
    // An empty head never advertises a write.
    if (!head_v_d) begin
      head_d.we = 1'b0;
    end else begin
      head_d.we = head_d.we;
    end
  end

  // Stage registers; in_ready is the registered complement of the next skid valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '{we: 1'b0, rd: {RA_W{1'b0}}, wdata: {DATA_W{1'b0}}};
      skid_q     <= '{we: 1'b0, rd: {RA_W{1'b0}}, wdata: {DATA_W{1'b0}}};
      head_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_v_q   <= head_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= ~skid_v_d;
    end
  end

  assign in_ready = in_ready_q;
  assign wb_valid = head_v_q;
  assign wb_we    = head_q.we;
  assign wb_rd    = head_q.rd;
  assign wb_wdata = head_q.wdata;

`ifdef MEM_WB_PIPE_PERF_EN
  logic [31:0] perf_retired_q, perf_stall_q;

  // Free-running retire/stall counters; survive flush, wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_retired_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      if (head_q.we & wb_ready & ~flush) begin
        perf_retired_q <= perf_retired_q + 32'd1;
      end
      if (head_v_q & ~wb_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe (DATA_W = 32) with a queue-based
// reference model. Perf checks are active when MEM_WB_PIPE_PERF_EN is defined.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mem_data;
  logic [31:0] in_alu_result;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [2:0]  in_ld_type;
  logic        in_link;
  logic [31:0] in_pc_plus4;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
`ifdef MEM_WB_PIPE_PERF_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_stall;
  int unsigned exp_retired;
  int unsigned exp_stall;
`endif

  always #5 clk = ~clk;

  mem_wb_pipe #(.DATA_W(32), .RA_W(5), .LINK_REG(31)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mem_data   (in_mem_data),
    .in_alu_result (in_alu_result),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .in_mem_to_reg (in_mem_to_reg),
    .in_ld_type    (in_ld_type),
    .in_link       (in_link),
    .in_pc_plus4   (in_pc_plus4),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_wdata      (wb_wdata)
`ifdef MEM_WB_PIPE_PERF_EN
    ,
    .perf_retired  (perf_retired),
    .perf_stall    (perf_stall)
`endif
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  ent_t        q[$];        // entries held by the stage, oldest first
  logic [31:0] obs_log[$];  // write data observed leaving the stage
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Load result from the architectural rules, using plain integer arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] m, input logic [31:0] addr,
                                           input logic [2:0] t);
    int unsigned off;
    int          x;
    off = addr % 32'd4;
    case (t)
      3'd0: begin x = int'((m >> (8 * off)) & 32'hFF); if (x > 127) x -= 256; end
      3'd1: x = int'((m >> (8 * off)) & 32'hFF);
      3'd2: begin x = int'((m >> (8 * (off - off % 2))) & 32'hFFFF); if (x > 32767) x -= 65536; end
      3'd3: x = int'((m >> (8 * (off - off % 2))) & 32'hFFFF);
      default: x = int'(m);
    endcase
    return 32'(x);
  endfunction

  function automatic ent_t model_entry();
    ent_t e;
    e.rd = in_link ? 5'd31 : in_rd;
    e.we = (in_reg_write || in_link) && (e.rd != 5'd0);
    if (in_link) e.wd = in_pc_plus4;
    else if (in_mem_to_reg) e.wd = ref_load(in_mem_data, in_alu_result, in_ld_type);
    else e.wd = in_alu_result;
    return e;
  endfunction

  task automatic check_outputs();
    check("wb_valid", 64'(wb_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      check("wb_we", 64'(wb_we), 64'(q[0].we));
      check("wb_rd", 64'(wb_rd), 64'(q[0].rd));
      check("wb_wdata", 64'(wb_wdata), 64'(q[0].wd));
    end else begin
      check("wb_we_idle", 64'(wb_we), 64'd0);
    end
`ifdef MEM_WB_PIPE_PERF_EN
    check("perf_retired", 64'(perf_retired), 64'(exp_retired));
    check("perf_stall", 64'(perf_stall), 64'(exp_stall));
`endif
  endtask

  // One clock: inputs are already driven (just after a falling edge).
  task automatic step();
    bit   out_x;
    bit   in_x;
    ent_t e;
    out_x = (q.size() > 0) && wb_ready && !flush;
    in_x  = in_valid && (q.size() < 2) && !flush;
    if (wb_valid && wb_ready && !flush) obs_log.push_back(wb_wdata);
    e = model_entry();
`ifdef MEM_WB_PIPE_PERF_EN
    if (out_x && q[0].we) exp_retired++;
    if ((q.size() > 0) && !wb_ready) exp_stall++;
`endif
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (out_x) q.delete(0);
      if (in_x) q.push_back(e);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_in(input logic v, input logic [31:0] mem, input logic [31:0] alu,
                        input logic [4:0] rd, input logic rw, input logic m2r,
                        input logic [2:0] lt, input logic link, input logic [31:0] pc);
    in_valid = v; in_mem_data = mem; in_alu_result = alu; in_rd = rd;
    in_reg_write = rw; in_mem_to_reg = m2r; in_ld_type = lt; in_link = link; in_pc_plus4 = pc;
  endtask

  task automatic idle_inputs();
    set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0);
    flush = 1'b0;
    wb_ready = 1'b1;
  endtask

  // Assert reset now (possibly mid-cycle), check it took hold at once, then release.
  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_wb_we"}, 64'(wb_we), 64'd0);
    check({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
    check({tag, "_wb_wdata"}, 64'(wb_wdata), 64'd0);
    q.delete();
    obs_log.delete();
`ifdef MEM_WB_PIPE_PERF_EN
    exp_retired = 0;
    exp_stall = 0;
`endif
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rel_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_rel_wb_valid"}, 64'(wb_valid), 64'd0);
  endtask

  logic [2:0]  lt_tab [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
  logic [31:0] off_tab[7] = '{32'd1, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
  logic [31:0] exp_tab[7] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h0000AABB,
                              32'h8899AABB, 32'h8899AABB, 32'h8899AABB};

  initial begin
    reset_n = 1'b1;
    idle_inputs();
    #2;
    apply_reset("rst_init");

    // Load extraction on a 32-bit datapath.
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, 32'h8899AABB, off_tab[i], 5'd5, 1'b1, 1'b1, lt_tab[i], 1'b0, 32'd0);
      step();
      check($sformatf("ld_tab_%0d", i), 64'(wb_wdata), 64'(exp_tab[i]));
    end

    // Link write goes to r31 with the return address; r0 writes are dropped.
    set_in(1'b1, 32'd0, 32'h55, 5'd7, 1'b0, 1'b0, 3'd4, 1'b1, 32'h1004);
    step();
    check("link_rd", 64'(wb_rd), 64'd31);
    check("link_we", 64'(wb_we), 64'd1);
    check("link_wdata", 64'(wb_wdata), 64'h1004);
    set_in(1'b1, 32'd0, 32'h1234, 5'd0, 1'b1, 1'b0, 3'd4, 1'b0, 32'd0);
    step();
    check("r0_we", 64'(wb_we), 64'd0);
    in_valid = 1'b0;
    step();

    // Backpressure: A in head, B in skid, C held by the source, then drain in order.
    obs_log.delete();
    wb_ready = 1'b0;
    set_in(1'b1, 32'd0, 32'hA, 5'd1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
    step();
    set_in(1'b1, 32'd0, 32'hB, 5'd2, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
    step();
    check("bp_in_ready_full", 64'(in_ready), 64'd0);
    set_in(1'b1, 32'd0, 32'hC, 5'd3, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
    step();
    check("bp_head_A", 64'(wb_wdata), 64'hA);
    check("bp_in_ready_held", 64'(in_ready), 64'd0);
    wb_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    step();
    check("bp_count", 64'(obs_log.size()), 64'd3);
    if (obs_log.size() == 3) begin
      check("bp_order_0", 64'(obs_log[0]), 64'hA);
      check("bp_order_1", 64'(obs_log[1]), 64'hB);
      check("bp_order_2", 64'(obs_log[2]), 64'hC);
    end

    // Flush with both entries full and a concurrent offer.
    wb_ready = 1'b0;
    set_in(1'b1, 32'd0, 32'hD, 5'd4, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
    step();
    set_in(1'b1, 32'd0, 32'hE, 5'd5, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
    step();
    set_in(1'b1, 32'd0, 32'hF, 5'd6, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_full_valid", 64'(wb_valid), 64'd0);
    check("flush_full_ready", 64'(in_ready), 64'd1);

    // Flush while in_ready is high: the offered input must not be captured.
    set_in(1'b1, 32'd0, 32'h10, 5'd7, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
    step();
    set_in(1'b1, 32'd0, 32'h11, 5'd8, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
    flush = 1'b1;
    wb_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_open_valid", 64'(wb_valid), 64'd0);
    step();
    check("flush_no_capture", 64'(wb_valid), 64'd0);

    // Reset mid-stream with head and skid both occupied.
    wb_ready = 1'b0;
    set_in(1'b1, 32'd0, 32'h20, 5'd9, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
    step();
    set_in(1'b1, 32'd0, 32'h21, 5'd10, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
    step();
    check("pre_rst_in_ready", 64'(in_ready), 64'd0);
    #2;
    apply_reset("rst_mid");
    step();
    check("rst_no_stale", 64'(wb_valid), 64'd0);

`ifdef MEM_WB_PIPE_PERF_EN
    // Ten writing retires followed by three stall cycles.
    apply_reset("rst_perf");
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'd0, 32'(i + 100), 5'(i + 1), 1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
      step();
    end
    in_valid = 1'b0;
    step();
    wb_ready = 1'b0;
    set_in(1'b1, 32'd0, 32'h77, 5'd3, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("perf_retired_10", 64'(perf_retired), 64'd10);
    check("perf_stall_3", 64'(perf_stall), 64'd3);
    wb_ready = 1'b1;
    step();
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 6)),
             ($urandom_range(0, 7) == 0), $urandom);
      wb_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 15) == 0);
      step();
    end
    idle_inputs();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM→WB pipeline stage; successor to the fixed 32-bit MEM/WB register.
- Adds a valid/ready handshake on both sides with a 2-entry skid buffer, so a stalled WB port does not drop or duplicate instructions.
- Adds synchronous flush.
- Performs load byte/half/word extraction with sign/zero extension before register-file write.
- Resolves link-register writes (jal) and suppresses writes to register 0.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- RA_W, 5, register-address width.
- LINK_REG, 31, destination register forced on link (jal) writes.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; kill all held entries.
- in_valid  in  1  MEM stage holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_mem_data  in  DATA_W  raw memory read word.
- in_alu_result  in  DATA_W  ALU result / load address.
- in_rd  in  RA_W  destination register.
- in_reg_write  in  1  instruction writes the register file.
- in_mem_to_reg  in  1  select load data.
- in_ld_type  in  3  ld_type_e: LB, LBU, LH, LHU, LW, LWU, LD.
- in_link  in  1  jal-type link write.
- in_pc_plus4  in  DATA_W  link value.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  WB stage consumes head.
- wb_we  out  1  final write enable.
- wb_rd  out  RA_W  final destination.
- wb_wdata  out  DATA_W  final write data.

Behaviour:
- Reset (reset_n low, asynchronous): both entry valids = 0, all payload = 0, wb_valid = 0, wb_we = 0, wb_rd = 0, wb_wdata = 0, in_ready = 1 after release.
- Write data is resolved at capture time, so outputs are pure register reads:
  - rd_final = in_link ? LINK_REG : in_rd.
  - we_final = (in_reg_write | in_link) & (rd_final != 0).
  - wdata = in_link ? in_pc_plus4 : in_mem_to_reg ? extract(in_mem_data) : in_alu_result.
- extract():
  - Byte offset = in_alu_result[log2(DATA_W/8)-1:0].
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD returns the full word.
  - Half/word offsets use the lane selected by the offset, aligned down to the access size.
  - LWU/LD on DATA_W=32 behave as LW.
- Storage: head register (drives wb_*) plus skid register.
- in_ready is the registered value of !skid_valid. It never depends combinationally on wb_ready.
- Transfer into the stage: in_valid & in_ready. Transfer out: wb_valid & wb_ready.
- Latency: 1 cycle from accepted input to wb_valid when the head is empty or being consumed. Sustained throughput is 1/cycle with wb_ready held high.
- Head empty or head consumed this cycle: new input → head, or skid → head if skid valid (skid has priority; ordering is preserved).
- Head held (wb_valid & !wb_ready) and input accepted: input → skid; in_ready drops the next cycle.
- Skid full: in_ready = 0. When the head drains, skid → head and in_ready returns to 1 the following cycle.
- flush = 1: both valids cleared at the next edge. In the flush cycle the input is not captured and the head is treated as not consumed. Flush has priority over every other event.
- Payload of invalid entries is don't-care. wb_we is forced 0 whenever wb_valid = 0.

Optional Feature:
- Macro MEM_WB_PIPE_PERF_EN.
- When defined, adds outputs perf_retired (32) and perf_stall (32):
  - perf_retired increments on each wb transfer with wb_we = 1.
  - perf_stall increments each cycle wb_valid & !wb_ready.
  - Both counters wrap modulo 2^32, reset to 0, and are not cleared by flush.
- When not defined, the ports and logic are absent.

Decomposition:
- Package mem_wb_pkg holds:
  - ld_type_e enum (3-bit encodings LB=0, LBU=1, LH=2, LHU=3, LW=4, LWU=5, LD=6).
  - wb_entry_t struct {we, rd, wdata} parametrised via localparams.
  - load_extract function.
- Sub-module mem_wb_load_align (combinational extraction) is natural and unit-testable.
- Skid logic stays in the top module.

Test Plan:
- Reset mid-stream:
  - Stimulus: two entries held (head and skid full), then reset_n pulsed low asynchronously.
  - Response: wb_valid = 0 and in_ready = 0 immediately; in_ready = 1 after release; no stale entry appears.
- Load extraction, DATA_W=32:
  - Stimulus: mem_data 0x8899AABB.
  - LB off=1 → 0xFFFFFFAA; LBU off=1 → 0x000000AA; LH off=2 → 0xFFFF8899; LHU off=0 → 0x0000AABB; LW → 0x8899AABB.
- Link and register 0:
  - Stimulus: in_link = 1, in_rd = 7, pc_plus4 = 0x1004.
  - Response: wb_rd = 31, wb_we = 1, wb_wdata = 0x1004.
  - Stimulus: in_reg_write = 1, in_rd = 0.
  - Response: wb_we = 0.
- Backpressure:
  - Stimulus: wb_ready = 0, inputs A, B, C offered on consecutive cycles.
  - Response: A in head, B in skid, in_ready = 0 and C held by the source.
  - Stimulus: wb_ready = 1.
  - Response: output order A, B, C; no loss or duplicate.
- Flush:
  - Stimulus: head and skid full, flush = 1 together with in_valid = 1.
  - Response: next cycle wb_valid = 0 and in_ready = 1; the flushed-cycle input is not captured.
- Perf counters (MEM_WB_PIPE_PERF_EN defined):
  - Stimulus: 10 writing retires, 3 stall cycles.
  - Response: perf_retired = 10, perf_stall = 3.
